usb_hub_repeater: RTL
=====================

# usb_hub_repeater

Parametrised full-speed hub repeater and downstream-port manager for `usb_hub_top`. It runs on the single `hi_clock` domain and works on synchronised, sampled line states. It tracks connect, enable and disconnect for each of `NUM_PORTS` downstream ports, and repeats packets host→enabled ports or one enabled port→host with one cycle of latency. It adds babble detection and automatic port disable on babble.

## Interface
- `NUM_PORTS`, 4: number of downstream ports (1..16).
- `DEBOUNCE_CYCLES`, 16: continuous idle-J cycles needed to declare an attach.
- `DISCONNECT_CYCLES`, 8: continuous SE0 cycles in route IDLE needed to declare a detach.
- `BABBLE_CYCLES`, 4096: maximum cycles a route may stay active.

Ports:
- `hi_clock`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `host_rx_line`  in  2  upstream line state {dp,dm}, already synchronised.
- `host_tx_line`  out  2  upstream drive value.
- `host_tx_oe`  out  1  upstream output enable.
- `dev_rx_line`  in  2*NUM_PORTS  downstream line states; port i is bits [2i+1:2i].
- `dev_tx_line`  out  2*NUM_PORTS  downstream drive values.
- `dev_tx_oe`  out  NUM_PORTS  downstream output enables.
- `port_enable`  in  NUM_PORTS  one-cycle enable request from the hub controller.
- `port_disable`  in  NUM_PORTS  one-cycle disable request.
- `port_connected`  out  NUM_PORTS  port state is not DISCONNECTED.
- `port_enabled`  out  NUM_PORTS  port state is ENABLED.
- `babble_err`  out  NUM_PORTS  one-cycle pulse when a port is disabled for babble.
- `route_state`  out  2  debug copy of the route FSM state.

## Operation
- Line encoding: J=2'b10, K=2'b01, SE0=2'b00, SE1=2'b11. SE1 is treated as J everywhere.
- Port FSM (one per port): DISCONNECTED → DISABLED → ENABLED.
  - DISCONNECTED→DISABLED: J held for `DEBOUNCE_CYCLES` consecutive cycles. Any non-J cycle restarts the count.
  - DISABLED→ENABLED: `port_enable` pulse.
  - ENABLED→DISABLED: `port_disable` pulse, or babble.
  - Any state→DISCONNECTED: SE0 held for `DISCONNECT_CYCLES` while the route is IDLE. The counter holds at 0 while the route is not IDLE.
  - `port_enable` and `port_disable` in the same cycle: disable wins. `port_enable` has no effect outside DISABLED.
- Route FSM states: IDLE(0), DOWN(1), UP(2), EOP(3).
  - IDLE→DOWN: `host_rx_line`==K. Host has priority over any device K in the same cycle.
  - IDLE→UP: no host K, and at least one ENABLED port shows K. The lowest-index such port is latched as the source. K on ports that are not ENABLED is ignored.
  - DOWN: `host_rx_line` is copied to `dev_tx_line` of every port that is ENABLED on entry, with their `dev_tx_oe` set. Ports that become disabled mid-packet stop being driven on the next cycle.
  - UP: the source port's rx line is copied to `host_tx_line` with `host_tx_oe`=1.
  - DOWN/UP→EOP: the source side shows SE0 followed by J. The first J is repeated, then EOP drives J for exactly one more cycle.
  - EOP→IDLE: all output enables drop.
- Babble: a route-cycle counter (width clog2(`BABBLE_CYCLES`)+1) clears on entering DOWN/UP. When it reaches `BABBLE_CYCLES`, the route is aborted and goes to IDLE with all output enables low next cycle.
  - If the route was UP, the source port goes to DISABLED and its `babble_err` pulses.
  - If the route was DOWN, no port changes state.
- Driven values are always J whenever the matching output enable is low.

## Timing
- Repeat latency is exactly 1 cycle. Input at edge n appears on tx and oe at edge n+1. All outputs are registered.
- Reset values: `host_tx_oe`=0, `dev_tx_oe`=0, `host_tx_line`=2'b10, every `dev_tx_line`=2'b10, `port_connected`=0, `port_enabled`=0, `babble_err`=0, `route_state`=0. All counters are 0.
- Reset asserted mid-packet: all outputs return to reset values asynchronously. After release, ports must re-debounce.
- `port_connected` rises on the cycle after the `DEBOUNCE_CYCLES`-th J sample.
- `port_enabled` rises on the cycle after the `port_enable` pulse.
- `babble_err` is high for exactly one cycle, coincident with `port_enabled` falling.

## Structure
- Package `usb_hub_pkg` holds:
  - line constants `LINE_J`, `LINE_K`, `LINE_SE0`, `LINE_SE1`;
  - port-state enum {DISCONNECTED, DISABLED, ENABLED};
  - route-state enum {IDLE, DOWN, UP, EOP}.
- Sub-module `usb_hub_port_fsm` holds one port's state, the debounce and disconnect counters, and the enable/disable logic. It is instantiated `NUM_PORTS` times in a generate loop.
- The route FSM, babble counter, source priority encoder and output muxing stay in the top of this block.

## Test plan
- Attach: port 2 idles J for 16 cycles → `port_connected[2]` rises at cycle 17. A K at cycle 10 restarts the count, so it rises at cycle 27 instead.
- Enable and downstream: ports 0 and 2 ENABLED. Host sends K,J,K,SE0,SE0,J → each symbol appears on `dev_tx_line[0]` and `dev_tx_line[2]` one cycle later, with oe high only on ports 0 and 2. Oe drops 2 cycles after the final J.
- Contention: host K and port 1 K in the same IDLE cycle → `route_state`=DOWN and `host_tx_oe` stays 0. Ports 1 and 3 K together with the host idle → route UP with port 1 as source.
- Babble: `BABBLE_CYCLES`=32, port 3 holds K forever → at cycle 32 the route goes IDLE, `babble_err[3]` pulses once and `port_enabled[3]`=0.
- Detach and reset: port 0 SE0 for 8 cycles while IDLE → `port_connected[0]`=0. SE0 during an UP route does not detach. `reset_n` low mid-DOWN → all oe 0 immediately.
- Enable/disable collision: `port_enable` and `port_disable` pulsed in the same cycle on a DISABLED port → the port stays DISABLED.

Source files
------------

// File: rtl/usb_hub_pkg.sv
// Shared line-state constants, state enums and line helpers for the hub repeater.
package usb_hub_pkg;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;
  localparam logic [1:0] LINE_SE1 = 2'b11;

  typedef enum logic [1:0] {
    DISCONNECTED = 2'd0,
    DISABLED     = 2'd1,
    ENABLED      = 2'd2
  } port_state_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOWN = 2'd1,
    UP   = 2'd2,
    EOP  = 2'd3
  } route_state_e;

  // SE1 is an illegal bus state and is folded into J wherever it is seen.
  function automatic logic is_j(input logic [1:0] line);
    return (line == LINE_J) || (line == LINE_SE1);
  endfunction

  function automatic logic [1:0] norm_line(input logic [1:0] line);
    return (line == LINE_SE1) ? LINE_J : line;
  endfunction

endpackage

// File: rtl/usb_hub_port_fsm.sv
// One downstream port: attach debounce, idle-time detach, and enable/disable/babble handling.
module usb_hub_port_fsm
  import usb_hub_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 16,
  parameter int unsigned DISCONNECT_CYCLES = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] rx_line_i,
  input  logic       route_idle_i,
  input  logic       enable_i,
  input  logic       disable_i,
  input  logic       babble_i,
  output logic       connected_o,
  output logic       enabled_o,
  output logic       babble_err_o
);

  localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned DiscW = $clog2(DISCONNECT_CYCLES + 1);
  localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DiscW-1:0] DiscLast = DiscW'(DISCONNECT_CYCLES - 1);

  port_state_e      state_q, state_d;
  logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [DiscW-1:0] disc_cnt_q, disc_cnt_d;
  logic             babble_err_q, babble_err_d;
  logic             detach;

  // Detach only counts while no packet is being routed; otherwise it sits at zero.
  always_comb begin
    disc_cnt_d = '0;
    detach     = 1'b0;
    if (route_idle_i && (rx_line_i == LINE_SE0)) begin
      if (disc_cnt_q == DiscLast) detach = 1'b1;
      else disc_cnt_d = disc_cnt_q + DiscW'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    deb_cnt_d    = '0;
    babble_err_d = 1'b0;
    case (state_q)
      DISCONNECTED: begin
        if (is_j(rx_line_i)) begin
          if (deb_cnt_q == DebLast) state_d = DISABLED;
          else deb_cnt_d = deb_cnt_q + DebW'(1);
        end
      end
      DISABLED: begin
        if (enable_i && !disable_i) state_d = ENABLED;
      end
      ENABLED: begin
        if (disable_i || babble_i) begin
          state_d      = DISABLED;
          babble_err_d = babble_i;
        end
      end
      default: state_d = DISCONNECTED;
    endcase
    if (detach) begin
      state_d      = DISCONNECTED;
      babble_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= DISCONNECTED;
      deb_cnt_q    <= '0;
      disc_cnt_q   <= '0;
      babble_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      deb_cnt_q    <= deb_cnt_d;
      disc_cnt_q   <= disc_cnt_d;
      babble_err_q <= babble_err_d;
    end
  end

  always_comb begin
    connected_o  = (state_q != DISCONNECTED);
    enabled_o    = (state_q == ENABLED);
    babble_err_o = babble_err_q;
  end

endmodule

// File: rtl/usb_hub_repeater.sv
// Full-speed hub repeater: routes host<->downstream packets with one cycle of latency,
// manages per-port state and aborts routes that run longer than the babble limit.
module usb_hub_repeater
  import usb_hub_pkg::*;
#(
  parameter int unsigned NUM_PORTS         = 4,
  parameter int unsigned DEBOUNCE_CYCLES   = 16,
  parameter int unsigned DISCONNECT_CYCLES = 8,
  parameter int unsigned BABBLE_CYCLES     = 4096
) (
  input  logic                   hi_clock,
  input  logic                   reset_n,
  input  logic [1:0]             host_rx_line,
  output logic [1:0]             host_tx_line,
  output logic                   host_tx_oe,
  input  logic [2*NUM_PORTS-1:0] dev_rx_line,
  output logic [2*NUM_PORTS-1:0] dev_tx_line,
  output logic [NUM_PORTS-1:0]   dev_tx_oe,
  input  logic [NUM_PORTS-1:0]   port_enable,
  input  logic [NUM_PORTS-1:0]   port_disable,
  output logic [NUM_PORTS-1:0]   port_connected,
  output logic [NUM_PORTS-1:0]   port_enabled,
  output logic [NUM_PORTS-1:0]   babble_err,
  output logic [1:0]             route_state
);

  localparam int unsigned SrcW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned BabW = $clog2(BABBLE_CYCLES) + 1;
  localparam logic [BabW-1:0] BabLimit = BabW'(BABBLE_CYCLES);

  route_state_e           route_q, route_d;
  logic [SrcW-1:0]        src_q, src_d;
  logic [NUM_PORTS-1:0]   mask_q, mask_d;
  logic                   up_q, up_d;
  logic                   se0_seen_q, se0_seen_d;
  logic [BabW-1:0]        bab_cnt_q, bab_cnt_d;
  logic [1:0]             host_line_q, host_line_d;
  logic                   host_oe_q, host_oe_d;
  logic [2*NUM_PORTS-1:0] dev_line_q, dev_line_d;
  logic [NUM_PORTS-1:0]   dev_oe_q, dev_oe_d;
  logic [NUM_PORTS-1:0]   babble_vec;
  logic                   dev_k_hit;
  logic [SrcW-1:0]        dev_k_idx;
  logic [1:0]             src_line;
  logic [1:0]             side_line;
  logic                   active_d;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    usb_hub_port_fsm #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .DISCONNECT_CYCLES(DISCONNECT_CYCLES)
    ) u_port (
      .clk_i       (hi_clock),
      .rst_ni      (reset_n),
      .rx_line_i   (dev_rx_line[2*g +: 2]),
      .route_idle_i(route_q == IDLE),
      .enable_i    (port_enable[g]),
      .disable_i   (port_disable[g]),
      .babble_i    (babble_vec[g]),
      .connected_o (port_connected[g]),
      .enabled_o   (port_enabled[g]),
      .babble_err_o(babble_err[g])
    );
  end

  // Lowest-index enabled port showing K wins the upstream route.
  always_comb begin
    dev_k_hit = 1'b0;
    dev_k_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (port_enabled[i] && (dev_rx_line[2*i +: 2] == LINE_K)) begin
        dev_k_hit = 1'b1;
        dev_k_idx = SrcW'(i);
      end
    end
  end

  always_comb begin
    src_line = LINE_J;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (src_q == SrcW'(i)) src_line = dev_rx_line[2*i +: 2];
    end
    side_line = up_q ? src_line : host_rx_line;
  end

  always_comb begin
    route_d    = route_q;
    src_d      = src_q;
    mask_d     = mask_q;
    up_d       = up_q;
    se0_seen_d = 1'b0;
    bab_cnt_d  = '0;
    babble_vec = '0;
    case (route_q)
      IDLE: begin
        if (host_rx_line == LINE_K) begin
          route_d = DOWN;
          up_d    = 1'b0;
          mask_d  = port_enabled;
        end else if (dev_k_hit) begin
          route_d = UP;
          up_d    = 1'b1;
          src_d   = dev_k_idx;
        end
      end
      DOWN, UP: begin
        bab_cnt_d = bab_cnt_q + BabW'(1);
        if (bab_cnt_d == BabLimit) begin
          route_d   = IDLE;
          bab_cnt_d = '0;
          for (int i = 0; i < NUM_PORTS; i++) begin
            if (up_q && (src_q == SrcW'(i))) babble_vec[i] = 1'b1;
          end
        end else begin
          se0_seen_d = (side_line == LINE_SE0);
          if (se0_seen_q && is_j(side_line)) route_d = EOP;
        end
      end
      default: route_d = IDLE;
    endcase
  end

  // The EOP state keeps the enables of the finished route up for one trailing J.
  always_comb begin
    active_d    = (route_d != IDLE) || (route_q == EOP);
    host_oe_d   = active_d && up_d;
    host_line_d = LINE_J;
    if (host_oe_d && (route_q == IDLE)) host_line_d = LINE_K;
    else if (host_oe_d && (route_q != EOP)) host_line_d = norm_line(src_line);
    dev_oe_d   = (active_d && !up_d) ? (mask_d & port_enabled) : '0;
    dev_line_d = {NUM_PORTS{LINE_J}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (dev_oe_d[i] && (route_q != EOP)) dev_line_d[2*i +: 2] = norm_line(host_rx_line);
    end
  end

  always_ff @(posedge hi_clock or negedge reset_n) begin
    if (!reset_n) begin
      route_q     <= IDLE;
      src_q       <= '0;
      mask_q      <= '0;
      up_q        <= 1'b0;
      se0_seen_q  <= 1'b0;
      bab_cnt_q   <= '0;
      host_line_q <= LINE_J;
      host_oe_q   <= 1'b0;
      dev_line_q  <= {NUM_PORTS{LINE_J}};
      dev_oe_q    <= '0;
    end else begin
      route_q     <= route_d;
      src_q       <= src_d;
      mask_q      <= mask_d;
      up_q        <= up_d;
      se0_seen_q  <= se0_seen_d;
      bab_cnt_q   <= bab_cnt_d;
      host_line_q <= host_line_d;
      host_oe_q   <= host_oe_d;
      dev_line_q  <= dev_line_d;
      dev_oe_q    <= dev_oe_d;
    end
  end

  assign host_tx_line = host_line_q;
  assign host_tx_oe   = host_oe_q;
  assign dev_tx_line  = dev_line_q;
  assign dev_tx_oe    = dev_oe_q;
  assign route_state  = route_q;

endmodule
